// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the HI/LO mul/div unit.
package muldiv_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFixup = 2'd2
    } state_e;

    function automatic logic is_muldiv_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on
// unsigned magnitudes held in {acc, q}.
module muldiv_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        shifted  = {acc, q[WIDTH-1]};
        diff     = shifted - {1'b0, m};
        acc_next = sum[WIDTH:1];
        q_next   = {sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            // Top bit of diff is the borrow: set means the trial subtract must be undone.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer with hazard stall.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, q_q, m_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div_q, neg_q, neg_rem_q, busy_q, done_q;

    logic               sa, sb, accept;
    logic [WIDTH-1:0]   a_mag, b_mag, acc_nx, q_nx;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign sa     = a[WIDTH-1] & is_signed_op(op);
    assign sb     = b[WIDTH-1] & is_signed_op(op);
    assign a_mag  = sa ? -a : a;
    assign b_mag  = sb ? -b : b;
    assign accept = start & ~flush & (state_q == StIdle);

    assign prod     = {acc_q, q_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -q_q : q_q;
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    muldiv_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .q        (q_q),
        .m        (m_q),
        .acc_next (acc_nx),
        .q_next   (q_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (op == MD_MTLO) begin
                            lo_q <= a;
                        end else if (is_muldiv_op(op)) begin
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            is_div_q  <= is_div_op(op);
                            neg_q     <= sa ^ sb;
                            neg_rem_q <= sa;
                            acc_q     <= '0;
                            if (is_div_op(op) && (b == '0)) begin
                                // Divide by zero: skip iteration, raw result lo=~0, hi=a.
                                acc_q     <= a;
                                q_q       <= '1;
                                neg_q     <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state_q   <= StFixup;
                            end else if (is_div_op(op)) begin
                                q_q     <= a_mag;
                                m_q     <= b_mag;
                                state_q <= StRun;
                            end else begin
`ifdef MULDIV_FAST_MULT_EN
                                {acc_q, q_q} <= fast_prod;
                                state_q      <= StFixup;
`else
                                q_q     <= b_mag;
                                m_q     <= a_mag;
                                state_q <= StRun;
`endif
                            end
                        end
                    end
                end
                StRun: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_nx;
                        q_q   <= q_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= StFixup;
                        end
                    end
                end
                StFixup: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (!flush) begin
                        done_q <= 1'b1;
                        hi_q   <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo_q   <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = busy_q & (start | rd_hilo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus scoreboard, and
// hand-written flush, hold-off, reset and ignored-op sequences.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    // Latency counts edges after the start edge until done is seen (edge E33 / E1).
    localparam int DIV_LAT = 33;
    localparam int DZ_LAT  = 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, flush, rd_hilo;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .rd_hilo (rd_hilo),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0]        ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MD_MULT:  return sx * sy;
            MD_MULTU: return ux * uy;
            MD_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            MD_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Present an op for one edge; leaves time at #1 after that start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input exp_t e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb_q.push_back(e);
        step();
        start = 1'b0;
        op    = MD_NOP;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string nm);
        int   lat, bc;
        exp_t e;
        wait_done(lat, bc);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_pending"}, 64'(sb_q.size()), 1);
        if (done && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({nm, "_hi"}, hi, e.hi);
            chk({nm, "_lo"}, lo, e.lo);
            chk({nm, "_lat"}, 64'(lat), 64'(e.lat));
            chk({nm, "_busycyc"}, 64'(bc), 64'(e.lat));
            chk({nm, "_busy_at_done"}, busy, 0);
        end
        step();
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        exp_t        e;
        int          n, bad, dseen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] m;

        tbl[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT};
        tbl[1]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
        tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        tbl[3]  = '{MD_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, DZ_LAT};
        tbl[4]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        tbl[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        tbl[6]  = '{MD_MULT,  32'd6,        32'd7,        32'd0,        32'd42,       MUL_LAT};
        tbl[7]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DZ_LAT};
        tbl[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
        tbl[9]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT};
        tbl[10] = '{MD_MULTU, 32'd0,        32'h00012345, 32'd0,        32'd0,        MUL_LAT};
        tbl[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, DIV_LAT};

        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        rd_hilo = 1'b0;
        op      = MD_NOP;
        a       = '0;
        b       = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        for (int i = 0; i < 12; i++) begin
            e.hi  = tbl[i].hi;
            e.lo  = tbl[i].lo;
            e.lat = tbl[i].lat;
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, e);
            check_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            ro = 3'(MD_MULT + 3'($urandom_range(0, 3)));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            m  = model(ro, ra, rb);
            e.hi  = m[63:32];
            e.lo  = m[31:0];
            e.lat = is_div_op(ro) ? ((rb == 32'd0) ? DZ_LAT : DIV_LAT) : MUL_LAT;
            issue(ro, ra, rb, 1'b1, e);
            check_result($sformatf("rnd%0d", i));
        end

        // MTHI/MTLO write in the sampling edge with no busy/done.
        issue(MD_MTHI, 32'h0000AAAA, 32'd0, 1'b0, e);
        chk("mthi_hi", hi, 32'h0000AAAA);
        chk("mthi_busy", busy, 0);
        issue(MD_MTLO, 32'h0000BBBB, 32'd0, 1'b0, e);
        chk("mtlo_lo", lo, 32'h0000BBBB);
        chk("mtlo_done", done, 0);

        // Flush on cycle 10 of a MULTU.
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, e);
`ifndef MULDIV_FAST_MULT_EN
        repeat (9) step();
        chk("flush_busy_before", busy, 1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        dseen = 0;
        repeat (40) begin
            if (done) dseen++;
            step();
        end
        chk("flush_no_done", 64'(dseen), 0);
        chk("flush_hi", hi, 32'h0000AAAA);
        chk("flush_lo", lo, 32'h0000BBBB);
        issue(MD_MTLO, 32'h00000055, 32'd0, 1'b0, e);
        chk("mtlo55_lo", lo, 32'h00000055);
        chk("mtlo55_hi", hi, 32'h0000AAAA);
        chk("mtlo55_busy", busy, 0);

        // start & flush in IDLE, and an undefined op, are ignored.
        flush = 1'b1;
        issue(MD_MTHI, 32'h00000001, 32'd0, 1'b0, e);
        chk("sflush_mthi_hi", hi, 32'h0000AAAA);
        issue(MD_MULT, 32'd3, 32'd3, 1'b0, e);
        flush = 1'b0;
        chk("sflush_mult_busy", busy, 0);
        issue(3'd7, 32'h12345678, 32'd9, 1'b0, e);
        chk("undef_busy", busy, 0);
        chk("undef_lo", lo, 32'h00000055);
        issue(MD_NOP, 32'h12345678, 32'd9, 1'b0, e);
        chk("nop_busy", busy, 0);

        // DIVU with rd_hilo and a MULT held off until the done cycle.
        e.hi  = 32'd1;
        e.lo  = 32'd333;
        e.lat = DIV_LAT;
        issue(MD_DIVU, 32'd1000, 32'd3, 1'b1, e);
        rd_hilo = 1'b1;
        n   = 0;
        bad = 0;
        while (!done && n < 200) begin
            if (n == 5) begin
                start = 1'b1;
                op    = MD_MULT;
                a     = 32'd5;
                b     = 32'hFFFFFFFC;
            end
            if (busy && stall !== 1'b1) bad++;
            step();
            n++;
        end
        chk("hold_stall_busy", 64'(bad), 0);
        chk("hold_done", done, 1);
        chk("hold_stall_done", stall, 0);
        chk("hold_lat", 64'(n), 64'(DIV_LAT));
        chk("hold_pending", 64'(sb_q.size()), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("hold_hi", hi, e.hi);
            chk("hold_lo", lo, e.lo);
        end
        e.hi  = 32'hFFFFFFFF;
        e.lo  = 32'hFFFFFFEC;
        e.lat = MUL_LAT;
        sb_q.push_back(e);
        step();
        start   = 1'b0;
        op      = MD_NOP;
        rd_hilo = 1'b0;
        chk("held_mult_busy", busy, 1);
        check_result("held_mult");

        // Reset mid-RUN discards the op and clears HI/LO.
        issue(MD_DIVU, 32'd50, 32'd3, 1'b0, e);
        repeat (5) step();
        chk("rstrun_busy_before", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done", done, 0);
        chk("rstrun_hi", hi, 0);
        chk("rstrun_lo", lo, 0);

        e.hi  = 32'd0;
        e.lo  = 32'd42;
        e.lat = MUL_LAT;
        issue(MD_MULTU, 32'd6, 32'd7, 1'b1, e);
        check_result("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
